// File: rtl/i8048_pmem_ctrl.sv
// i8048_pmem_ctrl: program-memory fetch controller for an 8048-class core.
// Resolves opcode/operand/MOVP/MOVP3 effective addresses, runs wait-stated
// ROM reads and keeps a one-entry sequential prefetch buffer so the next
// opcode/operand byte can be returned without touching the ROM.
module i8048_pmem_ctrl #(
    parameter int ADDR_W     = 12,
    parameter int PAGE_W     = 8,
    parameter int INC_W      = 11,
    parameter int WAIT       = 1,
    parameter int MOVP3_PAGE = 3,
    parameter int PREFETCH   = 1
) (
    input  logic              clk,
    input  logic              res,
    input  logic              fetch_req,
    input  logic [1:0]        fetch_kind,
    input  logic [ADDR_W-1:0] pc,
    input  logic [PAGE_W-1:0] acc,
    output logic [7:0]        fetch_data,
    output logic              fetch_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_cs,
    input  logic [7:0]        rom_data
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ACCESS     = 3'd1;
    localparam logic [2:0] S_CAPTURE    = 3'd2;
    localparam logic [2:0] S_PF_ACCESS  = 3'd3;
    localparam logic [2:0] S_PF_CAPTURE = 3'd4;

    localparam int              HI_W     = ADDR_W - PAGE_W;
    localparam logic [HI_W-1:0] MOVP3_HI = HI_W'(MOVP3_PAGE);
    localparam logic [3:0]      WAIT_CNT = 4'(WAIT);
    localparam logic            PF_EN    = (PREFETCH != 0);
    // Bits of the address that take part in the sequential increment; the
    // bank bits above them are carried through unchanged.
    localparam logic [ADDR_W-1:0] INC_MASK = ADDR_W'((64'd1 << INC_W) - 64'd1);

    logic [2:0]        state;
    logic [3:0]        wait_cnt;
    logic              seq_kind;   // latched access was opcode/operand
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;
    logic [7:0]        buf_data;
    logic [ADDR_W-1:0] eff_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              buf_hit;

    // Effective address selection by fetch kind.
    // NOTE: every always_comb output gets a value on every path (default arm
    // here) so no latch is inferred.
    always_comb begin
        case (fetch_kind)
            2'b10:   eff_addr = {pc[ADDR_W-1:PAGE_W], acc};
            2'b11:   eff_addr = {MOVP3_HI, acc};
            default: eff_addr = pc;
        endcase
    end

    assign next_addr = (rom_addr & ~INC_MASK) | ((rom_addr + ADDR_W'(1)) & INC_MASK);
    assign buf_hit   = PF_EN && buf_valid && !fetch_kind[1] && (eff_addr == buf_tag);
    assign busy      = (state != S_IDLE);

    // Access sequencer: state, wait counter, ROM strobe and core handshake.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            seq_kind   <= 1'b0;
            buf_valid  <= 1'b0;
            rom_addr   <= '0;
            rom_cs     <= 1'b0;
            fetch_ack  <= 1'b0;
            fetch_data <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    fetch_ack <= 1'b0;
                    if (fetch_req) begin
                        rom_addr <= eff_addr;
                        seq_kind <= !fetch_kind[1];
                        if (buf_hit) begin
                            fetch_data <= buf_data;
                            fetch_ack  <= 1'b1;
                            state      <= S_CAPTURE;
                        end else begin
                            rom_cs   <= 1'b1;
                            wait_cnt <= WAIT_CNT;
                            state    <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        fetch_data <= rom_data;
                        rom_cs     <= 1'b0;
                        fetch_ack  <= 1'b1;
                        state      <= S_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    fetch_ack <= 1'b0;
                    if (PF_EN && seq_kind) begin
                        rom_addr <= next_addr;
                        rom_cs   <= 1'b1;
                        wait_cnt <= WAIT_CNT;
                        state    <= S_PF_ACCESS;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_PF_ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        rom_cs <= 1'b0;
                        state  <= S_PF_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_PF_CAPTURE: begin
                    buf_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    rom_cs    <= 1'b0;
                    fetch_ack <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // Prefetch buffer storage, written with the byte read in the last
    // prefetch wait cycle.
    // NOTE: tag and data are deliberately not reset; buf_valid (cleared by
    // reset) guards them, so they stay plain storage.
    always_ff @(posedge clk) begin
        if (state == S_PF_ACCESS && wait_cnt == 4'd0) begin
            buf_data <= rom_data;
            buf_tag  <= rom_addr;
        end
    end

endmodule

// File: tb/tb_i8048_pmem_ctrl.sv
// Directed bench for i8048_pmem_ctrl: three builds (WAIT=1, 0, 15) share a
// ROM image; stimulus runs as one linear sequence of requests.
module tb_i8048_pmem_ctrl;

    logic        clk = 1'b0;
    logic        res;
    logic        req   [3];
    logic [1:0]  kind  [3];
    logic [11:0] pc    [3];
    logic [7:0]  acc   [3];
    logic [7:0]  fdata [3];
    logic        ack   [3];
    logic        bsy   [3];
    logic [11:0] raddr [3];
    logic        cs    [3];
    logic [7:0]  rdata [3];

    logic [7:0]  rom [4096];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rdata[0] = rom[raddr[0]];
    assign rdata[1] = rom[raddr[1]];
    assign rdata[2] = rom[raddr[2]];

    i8048_pmem_ctrl #(.WAIT(1)) dut (
        .clk(clk), .res(res), .fetch_req(req[0]), .fetch_kind(kind[0]),
        .pc(pc[0]), .acc(acc[0]), .fetch_data(fdata[0]), .fetch_ack(ack[0]),
        .busy(bsy[0]), .rom_addr(raddr[0]), .rom_cs(cs[0]), .rom_data(rdata[0])
    );

    i8048_pmem_ctrl #(.WAIT(0)) dut_w0 (
        .clk(clk), .res(res), .fetch_req(req[1]), .fetch_kind(kind[1]),
        .pc(pc[1]), .acc(acc[1]), .fetch_data(fdata[1]), .fetch_ack(ack[1]),
        .busy(bsy[1]), .rom_addr(raddr[1]), .rom_cs(cs[1]), .rom_data(rdata[1])
    );

    i8048_pmem_ctrl #(.WAIT(15)) dut_w15 (
        .clk(clk), .res(res), .fetch_req(req[2]), .fetch_kind(kind[2]),
        .pc(pc[2]), .acc(acc[2]), .fetch_data(fdata[2]), .fetch_ack(ack[2]),
        .busy(bsy[2]), .rom_addr(raddr[2]), .rom_cs(cs[2]), .rom_data(rdata[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on build d, starting just after a rising edge.
    // lat counts edges from the sampling edge up to the one after which ack
    // is seen; cs_n counts cycles with rom_cs high before the ack.
    task automatic request(input int d, input logic [1:0] k, input logic [11:0] p,
                           input logic [7:0] a, output int lat, output int cs_n,
                           output logic [11:0] addr);
        kind[d] = k; pc[d] = p; acc[d] = a; req[d] = 1'b1;
        lat = 0; cs_n = 0; addr = '0;
        while (lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                req[d]  = 1'b0;
                addr    = raddr[d];
                pc[d]   = ~p;      // core inputs are don't-care after sampling
                acc[d]  = ~a;
                kind[d] = ~k;
            end
            if (ack[d]) break;
            if (cs[d]) cs_n++;
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (bsy[d] !== 1'b0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle", 32'(bsy[d]), 32'd0);
    endtask

    initial begin
        int          lat;
        int          csn;
        int          nack;
        logic [11:0] ad;

        for (int i = 0; i < 4096; i++) rom[i] = 8'(i * 7 + 1);
        rom[12'h123] = 8'hA3;
        rom[12'h542] = 8'h5C;
        rom[12'h342] = 8'h3D;
        rom[12'h200] = 8'h11;
        rom[12'h201] = 8'h22;
        rom[12'hFFF] = 8'h77;
        rom[12'h000] = 8'h99;
        rom[12'h301] = 8'h31;
        rom[12'h401] = 8'h41;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; kind[i] = 2'b00; pc[i] = '0; acc[i] = '0;
        end

        // Reset state
        res = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;
        check("rst_rom_addr", 32'(raddr[0]), 32'h0);
        check("rst_rom_cs",   32'(cs[0]),    32'h0);
        check("rst_ack",      32'(ack[0]),   32'h0);
        check("rst_data",     32'(fdata[0]), 32'h0);
        check("rst_busy",     32'(bsy[0]),   32'h0);

        // Opcode miss at 0x123, then prefetch of 0x124
        request(0, 2'b00, 12'h123, 8'h00, lat, csn, ad);
        check("op_addr", 32'(ad),       32'h123);
        check("op_cs",   32'(csn),      32'd2);
        check("op_lat",  32'(lat),      32'd3);
        check("op_data", 32'(fdata[0]), 32'hA3);
        @(posedge clk); #1;
        check("op_ack_one", 32'(ack[0]),   32'h0);
        check("op_pf_cs",   32'(cs[0]),    32'h1);
        check("op_pf_addr", 32'(raddr[0]), 32'h124);
        wait_idle(0);

        // MOVP / MOVP3 addressing, no prefetch afterwards
        request(0, 2'b10, 12'h5F0, 8'h42, lat, csn, ad);
        check("movp_addr", 32'(ad),       32'h542);
        check("movp_data", 32'(fdata[0]), 32'h5C);
        @(posedge clk); #1;
        check("movp_nopf_busy", 32'(bsy[0]), 32'h0);
        check("movp_nopf_cs",   32'(cs[0]),  32'h0);
        request(0, 2'b11, 12'h5F0, 8'h42, lat, csn, ad);
        check("movp3_addr", 32'(ad),       32'h342);
        check("movp3_data", 32'(fdata[0]), 32'h3D);
        @(posedge clk); #1;
        check("movp3_nopf_busy", 32'(bsy[0]), 32'h0);

        // Prefetch hit on the operand following an opcode
        request(0, 2'b00, 12'h200, 8'h00, lat, csn, ad);
        check("pf_op_data", 32'(fdata[0]), 32'h11);
        wait_idle(0);
        request(0, 2'b01, 12'h201, 8'h00, lat, csn, ad);
        check("hit_lat",  32'(lat),      32'd1);
        check("hit_cs",   32'(csn),      32'd0);
        check("hit_data", 32'(fdata[0]), 32'h22);
        @(posedge clk); #1;
        check("hit_next_pf", 32'(raddr[0]), 32'h202);
        wait_idle(0);

        // Bank-preserving wrap: 0xFFF prefetches 0x800, 0x000 misses
        request(0, 2'b00, 12'hFFF, 8'h00, lat, csn, ad);
        check("wrap_data", 32'(fdata[0]), 32'h77);
        @(posedge clk); #1;
        check("wrap_pf_addr", 32'(raddr[0]), 32'h800);
        wait_idle(0);
        request(0, 2'b00, 12'h000, 8'h00, lat, csn, ad);
        check("wrap_miss_lat",  32'(lat),      32'd3);
        check("wrap_miss_data", 32'(fdata[0]), 32'h99);
        wait_idle(0);

        // MOVP to the buffered address neither hits nor disturbs the buffer
        request(0, 2'b00, 12'h300, 8'h00, lat, csn, ad);
        wait_idle(0);
        request(0, 2'b10, 12'h3F0, 8'h01, lat, csn, ad);
        check("movp_buf_lat",  32'(lat),      32'd3);
        check("movp_buf_data", 32'(fdata[0]), 32'h31);
        @(posedge clk); #1;
        request(0, 2'b01, 12'h301, 8'h00, lat, csn, ad);
        check("buf_kept_lat",  32'(lat),      32'd1);
        check("buf_kept_data", 32'(fdata[0]), 32'h31);
        wait_idle(0);

        // Reset during ACCESS; buffered 0x401 must miss afterwards
        request(0, 2'b00, 12'h400, 8'h00, lat, csn, ad);
        wait_idle(0);
        kind[0] = 2'b00; pc[0] = 12'h600; req[0] = 1'b1;
        @(posedge clk); #1;
        req[0] = 1'b0;
        check("mid_busy_pre", 32'(bsy[0]), 32'h1);
        res = 1'b1;
        #1;
        check("mid_rst_cs",   32'(cs[0]),    32'h0);
        check("mid_rst_busy", 32'(bsy[0]),   32'h0);
        check("mid_rst_ack",  32'(ack[0]),   32'h0);
        check("mid_rst_data", 32'(fdata[0]), 32'h0);
        #1;
        res = 1'b0;
        nack = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack[0]) nack++;
        end
        check("mid_rst_no_ack", 32'(nack), 32'd0);
        request(0, 2'b00, 12'h401, 8'h00, lat, csn, ad);
        check("post_rst_miss_lat",  32'(lat),      32'd3);
        check("post_rst_miss_data", 32'(fdata[0]), 32'h41);
        wait_idle(0);

        // WAIT=0 and WAIT=15 builds
        request(1, 2'b00, 12'h123, 8'h00, lat, csn, ad);
        check("w0_lat",  32'(lat),      32'd2);
        check("w0_cs",   32'(csn),      32'd1);
        check("w0_data", 32'(fdata[1]), 32'hA3);
        request(2, 2'b00, 12'h123, 8'h00, lat, csn, ad);
        check("w15_lat",  32'(lat),      32'd17);
        check("w15_cs",   32'(csn),      32'd16);
        check("w15_data", 32'(fdata[2]), 32'hA3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
